// File: rtl/cdc_handshake_tx_controller.sv
// cdc_handshake_tx_controller: source-side sequencer that holds a word stable on a
// wide-synchronized bus, then toggles req and waits for the synchronized toggle ack.
module cdc_handshake_tx_controller #(
    parameter int WIDTH          = 8,
    parameter int SETTLE_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] xfer_data,
    output logic             xfer_req,
    input  logic             xfer_ack,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    input  logic             err_clear
);
    localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, WAIT_ACK} state_t;
    state_t state, state_n;

    logic          ack_s1, ack_s2;
    logic [7:0]    scnt;
    logic [TW-1:0] tcnt;
    logic          accept, fire, match, tick, err_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        in_ready = state == IDLE;
        busy     = state != IDLE;
        accept   = in_ready & in_valid;
        fire     = state == SETTLE && scnt == 8'd0;
        match    = state == WAIT_ACK && ack_s2 == xfer_req;
        // Counter saturates at the limit so a late ack can still complete
        tick     = state == WAIT_ACK && !match && TIMEOUT_CYCLES > 0 && tcnt != TLIM;
        err_set  = tick && (tcnt + TW'(1)) == TLIM;
        if (accept)     state_n = SETTLE;
        else if (fire)  state_n = WAIT_ACK;
        else if (match) state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_s1      <= 1'b0;
            ack_s2      <= 1'b0;
            xfer_data   <= '0;
            xfer_req    <= 1'b0;
            scnt        <= 8'd0;
            tcnt        <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ack_s1      <= xfer_ack;
            ack_s2      <= ack_s1;
            xfer_data   <= accept ? in_data : xfer_data;
            scnt        <= accept ? 8'(SETTLE_CYCLES - 1) : (state == SETTLE && !fire) ? scnt - 8'd1 : scnt;
            xfer_req    <= fire ? ~xfer_req : xfer_req;
            tcnt        <= fire ? '0 : tick ? tcnt + TW'(1) : tcnt;
            done        <= match;
            timeout_err <= err_set | (timeout_err & ~err_clear);
        end
    end
endmodule
